mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 12 +
 rtl/mem_array.sv | 29 ++
 rtl/mem_responder.sv | 105 ++++++++++
 tb/tb_mem_responder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared state encoding and default geometry for mem_responder and its bench.
package mem_pkg;

  typedef enum logic {
    MEM_INIT  = 1'b0,
    MEM_READY = 1'b1
  } mem_state_e;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/mem_array.sv
// Single-port word store: synchronous write, registered read that holds between reads.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents are left unreset; the post-reset sweep defines every word.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: post-reset init sweep, then one read/write request per cycle.
// Optional per-word even parity when MEM_PARITY_EN is defined.
module mem_responder
  import mem_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter int              DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              parity_inject,
  output logic [DATA_W-1:0] dataout,
  output logic              rd_valid,
  output logic              ready,
  output logic              parity_err
);

`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  mem_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [WORD_W-1:0] arr_wdata, arr_rdata;
  logic [DATA_W-1:0] wr_data;
  logic              wr_inj;
  logic              rd_acc, rd_vld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= MEM_INIT;
      cnt      <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rd_vld_q <= rd_acc;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = addr;
    wr_data   = datain;
    wr_inj    = parity_inject;
    rd_acc    = 1'b0;
    case (state)
      MEM_INIT: begin
        arr_we   = 1'b1;
        arr_addr = cnt;
        wr_data  = INIT_VAL;
        wr_inj   = 1'b0;
        // Stop at the last word rather than wrapping back to zero.
        if (cnt == '1) state_nxt = MEM_READY;
        else           cnt_nxt   = cnt + 1'b1;
      end
      MEM_READY: begin
        arr_we = we;
        arr_re = ~we;
        rd_acc = ~we;
      end
      default: state_nxt = MEM_INIT;
    endcase
  end

`ifdef MEM_PARITY_EN
  assign arr_wdata  = {(^wr_data) ^ wr_inj, wr_data};
  // Even parity: a clean word XORs to zero across data and parity bit.
  assign parity_err = rd_vld_q & (^arr_rdata);
`else
  logic unused_inj;
  assign unused_inj = wr_inj;
  assign arr_wdata  = wr_data;
  assign parity_err = 1'b0;
`endif

  mem_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign dataout  = arr_rdata[DATA_W-1:0];
  assign rd_valid = rd_vld_q;
  assign ready    = (state == MEM_READY);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: reference memory model, timed read expectations.
module tb_mem_responder;
  import mem_pkg::*;

`ifdef MEM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] datain, addr, dataout;
  logic       we, parity_inject, rd_valid, ready, parity_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         due;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] model     [256];
  logic       model_inj [256];

  mem_responder #(.ADDR_W(ADDR_W_DEF), .DATA_W(DATA_W_DEF), .INIT_VAL(8'h00)) dut (
    .clk           (clk),
    .reset         (reset),
    .datain        (datain),
    .addr          (addr),
    .we            (we),
    .parity_inject (parity_inject),
    .dataout       (dataout),
    .rd_valid      (rd_valid),
    .ready         (ready),
    .parity_err    (parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) begin
      model[i]     = 8'h00;
      model_inj[i] = 1'b0;
    end
  endtask

  // Called at a falling edge: drive one request, record what it should produce.
  task automatic drive(input logic w, input logic [7:0] a, input logic [7:0] d, input logic inj);
    exp_t e;
    we = w; addr = a; datain = d; parity_inject = inj;
    if (ready && reset) begin
      if (w) begin
        model[a]     = d;
        model_inj[a] = inj;
      end else begin
        e.data = model[a];
        e.perr = PAR_ON & model_inj[a];
        e.due  = cyc + 1;
        sb.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic count_init(input string tag);
    int n = 0;
    while (!ready && n < 1000) begin
      n++;
      drive(n[0], 8'h20, 8'h55, 1'b0);
    end
    chk(tag, 32'(n), 32'd256);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("dataout", 32'(dataout), 32'(sb[0].data));
      chk("parity_err", 32'(parity_err), 32'(sb[0].perr));
      void'(sb.pop_front());
    end else begin
      chk("rd_valid_idle", 32'(rd_valid), 32'd0);
      chk("perr_idle", 32'(parity_err), 32'd0);
    end
  end

  initial begin
    reset = 1'b0; we = 1'b0; addr = '0; datain = '0; parity_inject = 1'b0;
    clear_model();
    @(negedge clk);
    chk("rst_dataout", 32'(dataout), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    reset = 1'b1;

    // Init sweep with requests that must all be ignored (incl. write 0x55 to 0x20).
    count_init("init_len");
    chk("dout_hold_init", 32'(dataout), 32'd0);
    drive(1'b0, 8'h20, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'h7F, 8'h00, 1'b0);
    drive(1'b0, 8'hFF, 8'h00, 1'b0);

    drive(1'b1, 8'h10, 8'hA5, 1'b0);
    drive(1'b0, 8'h10, 8'h00, 1'b0);

    drive(1'b1, 8'h00, 8'h11, 1'b0);
    drive(1'b1, 8'h01, 8'h22, 1'b0);
    drive(1'b1, 8'hFF, 8'h33, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'h01, 8'h00, 1'b0);
    drive(1'b0, 8'hFF, 8'h00, 1'b0);

    for (int i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'b0);

    drive(1'b1, 8'h40, 8'h3C, 1'b1);
    drive(1'b0, 8'h40, 8'h00, 1'b0);
    drive(1'b1, 8'h41, 8'h3C, 1'b0);
    drive(1'b0, 8'h41, 8'h00, 1'b0);

    // Reset during operation, then again partway through the resulting sweep.
    #2 reset = 1'b0;
    clear_model();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    repeat (100) drive(1'b0, 8'h10, 8'h00, 1'b0);
    chk("ready_mid_sweep", 32'(ready), 32'd0);
    #2 reset = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    count_init("init_len_restart");
    drive(1'b0, 8'h10, 8'h00, 1'b0);
    drive(1'b0, 8'h40, 8'h00, 1'b0);
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 8'h00, 1'b0);

    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
